// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sub_pkg;

  // Sequencer states: wait for start, shift one bit per edge, present result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; never below one bit so tiny widths still elaborate.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the serial subtractor: start/done pulse pair plus data.
// Latency: n/a (wiring only).
// Backpressure: none; start is ignored while busy, never queued.
interface serial_subtractor_if #(
  parameter int WIDTH = sub_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  // Requester side: issues operands and start, observes results.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  // Subtractor side: consumes operands, drives results.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/fs.sv
// One-bit full-subtractor cell: diff = a - b - cin, borrow out on brr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle by its driver.
module fs (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic brr,
  output logic diff
);

  assign diff = a ^ b ^ cin;
  assign brr  = (~a & b) | (b & cin) | (~a & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered borrow.
// Latency: WIDTH cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave sub_if
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               cell_d;
  logic               cell_br;
  logic               last_bit;
  logic               busy;
  logic               done;

  // The single arithmetic cell always sees the current LSBs and running borrow.
  fs u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (br_q),
    .brr  (cell_br),
    .diff (cell_d)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, leave SHIFT after the MSB, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sub_if.start) state_d = SHIFT;
      SHIFT:   if (last_bit)     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode directly from the state register, so they are glitch-free.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: load on accept, then shift one bit per SHIFT edge.
  always_comb begin
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    diff_d = diff_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (sub_if.start) begin
          a_sr_d = sub_if.a;
          b_sr_d = sub_if.b;
          br_d   = sub_if.bin;
          cnt_d  = '0;
          diff_d = '0;
        end
      end
      SHIFT: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        br_d   = cell_br;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // br_q is the borrow into the MSB stage here; signed overflow is
          // that borrow differing from the borrow out of the MSB.
          bout_d = cell_br;
          ovf_d  = br_q ^ cell_br;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; results hold until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      diff_q <= diff_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sub_if.busy = busy;
  assign sub_if.done = done;
  assign sub_if.diff = diff_q;
  assign sub_if.bout = bout_q;
  assign sub_if.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed scoreboard bench for the bit-serial subtractor.
// Latency: expects done WIDTH cycles after each accepted start.
// Backpressure: models start being ignored while an operation is in progress.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sub_if (sif)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mcnt   = 0;
  int   n_acc  = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;
  logic         last_ovf  = 1'b0;
  logic         prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from plain integers: unsigned borrow and signed range.
  function automatic exp_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin);
    exp_t e;
    int ua, ub, full, sa, sb_v, sd;
    ua   = int'(ra);
    ub   = int'(rb);
    full = ua - ub - int'(rbin);
    sa   = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb_v = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sd   = sa - sb_v - int'(rbin);
    e.a    = ra;
    e.b    = rb;
    e.bin  = rbin;
    e.diff = full[W-1:0];
    e.bout = (ua < ub + int'(rbin));
    e.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    e.cyc  = 0;
    return e;
  endfunction

  // Request model: an accepted start occupies the block for W+1 edges.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst_n) begin
      sb.delete();
      mcnt      = 0;
      last_diff = '0;
      last_bout = 1'b0;
      last_ovf  = 1'b0;
    end else if (mcnt == 0) begin
      if (sif.start) begin
        e     = ref_model(sif.a, sif.b, sif.bin);
        e.cyc = cyc + W;
        sb.push_back(e);
        mcnt  = W + 1;
        n_acc = n_acc + 1;
      end
    end else begin
      mcnt = mcnt - 1;
    end
  end

  // Monitor: compare every done against the scoreboard, and held outputs while idle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(sif.busy), 32'(mcnt != 0));
      if (sif.done) begin
        chk("done_width", 32'(prev_done), 32'(0));
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no outstanding request (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("diff",    32'(sif.diff), 32'(mon_e.diff));
          chk("bout",    32'(sif.bout), 32'(mon_e.bout));
          chk("ovf",     32'(sif.ovf),  32'(mon_e.ovf));
          chk("latency", 32'(cyc),      32'(mon_e.cyc));
          if (sif.diff === mon_e.diff && sif.bout === mon_e.bout && sif.ovf === mon_e.ovf)
            $display("PASS a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d",
                     mon_e.a, mon_e.b, mon_e.bin, sif.diff, sif.bout, sif.ovf);
          last_diff = mon_e.diff;
          last_bout = mon_e.bout;
          last_ovf  = mon_e.ovf;
        end
      end else if (mcnt == 0) begin
        chk("hold_diff", 32'(sif.diff), 32'(last_diff));
        chk("hold_bout", 32'(sif.bout), 32'(last_bout));
        chk("hold_ovf",  32'(sif.ovf),  32'(last_ovf));
      end
    end
    prev_done = sif.done;
  end

  task automatic wait_idle();
    int t = 0;
    while (mcnt != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (mcnt != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", t);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    @(negedge clk);
    sif.a     = ta;
    sif.b     = tb_v;
    sif.bin   = tbin;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int base;
    int t;
    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    sif.bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(sif.busy), 32'(0));
    chk("rst_done", 32'(sif.done), 32'(0));
    chk("rst_diff", 32'(sif.diff), 32'(0));
    chk("rst_bout", 32'(sif.bout), 32'(0));
    chk("rst_ovf",  32'(sif.ovf),  32'(0));
    #2 rst_n = 1'b1;

    // Directed corner cases.
    run_op(8'd5,   8'd3,   1'b0);
    run_op(8'h00,  8'h01,  1'b0);
    run_op(8'h80,  8'h01,  1'b0);
    run_op(8'h10,  8'h0F,  1'b1);
    run_op(8'h00,  8'h00,  1'b1);
    run_op(8'h7F,  8'hFF,  1'b0);

    // Start held high with changing operands: only idle-time starts count.
    @(negedge clk);
    base      = n_acc;
    sif.a     = 8'h3C;
    sif.b     = 8'h5A;
    sif.bin   = 1'b0;
    sif.start = 1'b1;
    @(negedge clk);
    sif.a     = 8'hC3;
    sif.b     = 8'h11;
    sif.bin   = 1'b1;
    t = 0;
    while (n_acc < base + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    sif.start = 1'b0;
    chk("held_start_accepts", 32'(n_acc - base), 32'(2));
    wait_idle();

    // Reset in the middle of an operation, during bit 3.
    @(negedge clk);
    sif.a     = 8'hA5;
    sif.b     = 8'h5A;
    sif.bin   = 1'b1;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(sif.busy), 32'(0));
    chk("midrst_done", 32'(sif.done), 32'(0));
    chk("midrst_diff", 32'(sif.diff), 32'(0));
    chk("midrst_bout", 32'(sif.bout), 32'(0));
    chk("midrst_ovf",  32'(sif.ovf),  32'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(8'h22, 8'h33, 1'b0);

    // Random operands.
    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
